plru_ctrl: RTL and testbench

Sequencer for the 4-way tree-PLRU state array in the data cache: arbitrates between the hit path (MRU touches) and the miss path (victim lookup / allocation), issues reads on the array's port 0 and read-modify-writes on port 1, and runs a bulk re-initialisation walk on request. Sits between the cache control FSM and the dual-port LRU state array.

---
 rtl/lru_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 26 ++
 rtl/plru_ctrl.sv | 138 +++++++++++++
 tb/tb_plru_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lru_pkg.sv
// rtl/lru_pkg.sv - 4-way tree-PLRU state type, controller states and victim/touch helpers
package lru_pkg;

  typedef logic [2:0] plru_t;

  typedef enum logic {
    RUN  = 1'b0,
    INIT = 1'b1
  } state_e;

  // b0 picks the half, b1/b2 pick the leaf inside that half
  function automatic logic [1:0] plru_victim(input plru_t s);
    if (!s[0]) return {1'b0, s[1]};
    return {1'b1, s[2]};
  endfunction

  function automatic plru_t plru_touch(input plru_t s, input logic [1:0] way);
    plru_t n;
    n    = s;
    n[0] = ~way[1];
    if (way[1]) n[2] = ~way[0];
    else        n[1] = ~way[0];
    return n;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter; pointer moves only on contention
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] rdy,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    rdy[0] = en && (!req[1] || (ptr_q == 1'b0));
    rdy[1] = en && (!req[0] || (ptr_q == 1'b1));
    gnt    = req & rdy;
    ptr_d  = ptr_q;
    if (en && (req == 2'b11)) ptr_d = ~ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/plru_ctrl.sv
// rtl/plru_ctrl.sv - PLRU state sequencer: hit/miss arbitration, port-0 read, port-1 RMW, init walk
module plru_ctrl
  import lru_pkg::*;
#(
  parameter int S_INDEX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init_req,
  output logic               init_busy,
  input  logic               hit_valid,
  output logic               hit_ready,
  input  logic [S_INDEX-1:0] hit_set,
  input  logic [1:0]         hit_way,
  input  logic               miss_valid,
  output logic               miss_ready,
  input  logic [S_INDEX-1:0] miss_set,
  input  logic               miss_alloc,
  output logic               rsp_valid,
  output logic [1:0]         rsp_way,
  output logic               lru_csb0,
  output logic               lru_web0,
  output logic [S_INDEX-1:0] lru_addr0,
  output logic [2:0]         lru_din0,
  input  logic [2:0]         lru_dout0,
  output logic               lru_csb1,
  output logic               lru_web1,
  output logic [S_INDEX-1:0] lru_addr1,
  output logic [2:0]         lru_din1
);

  state_e             state_q, state_d;
  logic [S_INDEX-1:0] cnt_q, cnt_d;
  logic               s1_valid_q, s1_valid_d;
  logic               s1_miss_q, s1_miss_d;
  logic               s1_alloc_q, s1_alloc_d;
  logic [S_INDEX-1:0] s1_set_q, s1_set_d;
  logic [1:0]         s1_way_q, s1_way_d;

  logic               arb_en;
  logic [1:0]         arb_rdy, arb_gnt;
  logic [1:0]         victim;

  assign arb_en = !rst && (state_q == RUN) && !init_req;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req ({miss_valid, hit_valid}),
    .rdy (arb_rdy),
    .gnt (arb_gnt)
  );

  assign hit_ready  = arb_rdy[0];
  assign miss_ready = arb_rdy[1];
  assign victim     = plru_victim(lru_dout0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    s1_valid_d = |arb_gnt;
    s1_miss_d  = arb_gnt[1];
    s1_alloc_d = miss_alloc;
    s1_set_d   = arb_gnt[1] ? miss_set : hit_set;
    s1_way_d   = hit_way;

    init_busy  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_way    = 2'd0;
    lru_csb0   = 1'b1;
    lru_web0   = 1'b1;
    lru_addr0  = '0;
    lru_din0   = '0;
    lru_csb1   = 1'b1;
    lru_web1   = 1'b1;
    lru_addr1  = '0;
    lru_din1   = '0;

    if (!rst) begin
      if (|arb_gnt) begin
        lru_csb0  = 1'b0;
        lru_addr0 = s1_set_d;
      end

      // Stage 1: the read issued last cycle is on lru_dout0 now
      if (s1_valid_q) begin
        if (s1_miss_q) begin
          rsp_valid = 1'b1;
          rsp_way   = victim;
        end
        if (!s1_miss_q || s1_alloc_q) begin
          lru_csb1  = 1'b0;
          lru_web1  = 1'b0;
          lru_addr1 = s1_set_q;
          lru_din1  = plru_touch(lru_dout0, s1_miss_q ? victim : s1_way_q);
        end
      end

      unique case (state_q)
        RUN: begin
          if (init_req) state_d = INIT;
        end
        INIT: begin
          init_busy = 1'b1;
          lru_csb1  = 1'b0;
          lru_web1  = 1'b0;
          lru_addr1 = cnt_q;
          lru_din1  = '0;
          cnt_d     = cnt_q + 1'b1;
          if (&cnt_q) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_miss_q  <= 1'b0;
      s1_alloc_q <= 1'b0;
      s1_set_q   <= '0;
      s1_way_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_miss_q  <= s1_miss_d;
      s1_alloc_q <= s1_alloc_d;
      s1_set_q   <= s1_set_d;
      s1_way_q   <= s1_way_d;
    end
  end

endmodule

// File: tb/tb_plru_ctrl.sv
// tb/tb_plru_ctrl.sv - randomized scoreboard bench for plru_ctrl with a forwarding dual-port array model
module tb_plru_ctrl;

  localparam int S_INDEX  = 4;
  localparam int NUM_SETS = 2 ** S_INDEX;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               init_req = 1'b0;
  logic               init_busy;
  logic               hit_valid = 1'b0;
  logic               hit_ready;
  logic [S_INDEX-1:0] hit_set = '0;
  logic [1:0]         hit_way = '0;
  logic               miss_valid = 1'b0;
  logic               miss_ready;
  logic [S_INDEX-1:0] miss_set = '0;
  logic               miss_alloc = 1'b0;
  logic               rsp_valid;
  logic [1:0]         rsp_way;
  logic               lru_csb0, lru_web0, lru_csb1, lru_web1;
  logic [S_INDEX-1:0] lru_addr0, lru_addr1;
  logic [2:0]         lru_din0, lru_din1;
  logic [2:0]         lru_dout0 = '0;

  always #5 clk = ~clk;

  plru_ctrl #(.S_INDEX(S_INDEX)) dut (
    .clk(clk), .rst(rst), .init_req(init_req), .init_busy(init_busy),
    .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_set(hit_set), .hit_way(hit_way),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_set(miss_set), .miss_alloc(miss_alloc),
    .rsp_valid(rsp_valid), .rsp_way(rsp_way),
    .lru_csb0(lru_csb0), .lru_web0(lru_web0), .lru_addr0(lru_addr0), .lru_din0(lru_din0),
    .lru_dout0(lru_dout0),
    .lru_csb1(lru_csb1), .lru_web1(lru_web1), .lru_addr1(lru_addr1), .lru_din1(lru_din1)
  );

  // Array model: registered read, write-through forwarding on a same-cycle same-address write
  logic [2:0] mem [NUM_SETS];
  initial for (int i = 0; i < NUM_SETS; i++) mem[i] = 3'd0;
  always @(posedge clk) begin
    if (!lru_csb0)
      lru_dout0 <= (!lru_csb1 && !lru_web1 && lru_addr1 == lru_addr0) ? lru_din1 : mem[lru_addr0];
    if (!lru_csb1 && !lru_web1) mem[lru_addr1] <= lru_din1;
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference PLRU: b0 chooses the half holding the victim, b1/b2 the leaf within it
  function automatic int m_victim(input int s);
    int b0 = s % 2;
    int b1 = (s / 2) % 2;
    int b2 = (s / 4) % 2;
    return (b0 == 1) ? 2 + b2 : b1;
  endfunction

  function automatic int m_touch(input int s, input int w);
    int b0 = s % 2;
    int b1 = (s / 2) % 2;
    int b2 = (s / 4) % 2;
    if (w < 2) begin
      b0 = 1;
      b1 = (w == 0) ? 1 : 0;
    end else begin
      b0 = 0;
      b2 = (w == 2) ? 1 : 0;
    end
    return b0 + 2 * b1 + 4 * b2;
  endfunction

  typedef struct { int cyc; int way; } rsp_t;
  typedef struct { int cyc; int addr; int data; } wr_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  int   ref_st [NUM_SETS];
  int   ptr_m = 0;
  int   walk_left = 0;
  bit   sb_en = 1'b1;
  bit   chk_arb = 1'b0;

  initial for (int i = 0; i < NUM_SETS; i++) ref_st[i] = 0;

  // Monitor: pops expected responses/writes, then records newly accepted requests
  always @(negedge clk) begin
    rsp_t r;
    wr_t  w;
    int   v;
    int   nv;
    if (rsp_valid) begin
      if (rsp_q.size() == 0) check("rsp_unexpected", 1, 0);
      else begin
        r = rsp_q.pop_front();
        check("rsp_cycle", cyc, r.cyc);
        check("rsp_way", int'(rsp_way), r.way);
      end
    end
    if (!lru_csb1 && !lru_web1) begin
      if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        w = wr_q.pop_front();
        check("wr_cycle", cyc, w.cyc);
        check("wr_addr", int'(lru_addr1), w.addr);
        check("wr_data", int'(lru_din1), w.data);
      end
    end
    if (rst) begin
      ptr_m = 0;
      walk_left = 0;
      rsp_q.delete();
      wr_q.delete();
    end else if (sb_en) begin
      if (hit_valid && miss_valid) begin
        check("ready_exclusive", int'(hit_ready && miss_ready), 0);
        if (hit_ready || miss_ready) begin
          if (chk_arb) begin
            check("arb_hit_ready", int'(hit_ready), int'(ptr_m == 0));
            check("arb_miss_ready", int'(miss_ready), int'(ptr_m == 1));
          end
          ptr_m = 1 - ptr_m;
        end
      end
      if (hit_valid && hit_ready) begin
        ref_st[hit_set] = m_touch(ref_st[hit_set], int'(hit_way));
        wr_q.push_back('{cyc: cyc + 1, addr: int'(hit_set), data: ref_st[hit_set]});
      end
      if (miss_valid && miss_ready) begin
        v = m_victim(ref_st[miss_set]);
        rsp_q.push_back('{cyc: cyc + 1, way: v});
        if (miss_alloc) begin
          ref_st[miss_set] = m_touch(ref_st[miss_set], v);
          wr_q.push_back('{cyc: cyc + 1, addr: int'(miss_set), data: ref_st[miss_set]});
        end
      end
      if (walk_left > 0) walk_left--;
      else if (init_req) begin
        for (int i = 0; i < NUM_SETS; i++) begin
          wr_q.push_back('{cyc: cyc + 1 + i, addr: i, data: 0});
          ref_st[i] = 0;
        end
        walk_left = NUM_SETS;
      end
      nv = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hit_valid  = 1'b0;
    miss_valid = 1'b0;
    init_req   = 1'b0;
  endtask

  task automatic hit_op(input int s, input int w);
    bit done = 1'b0;
    hit_valid = 1'b1;
    hit_set   = S_INDEX'(s);
    hit_way   = 2'(w);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (hit_ready) done = 1'b1;
      tick();
    end
    if (!done) check("hit_accept_timeout", 0, 1);
  endtask

  task automatic miss_op(input int s, input bit alloc);
    bit done = 1'b0;
    miss_valid = 1'b1;
    miss_set   = S_INDEX'(s);
    miss_alloc = alloc;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (miss_ready) done = 1'b1;
      tick();
    end
    if (!done) check("miss_accept_timeout", 0, 1);
  endtask

  task automatic drain();
    idle();
    repeat (4) tick();
    check("rsp_q_drained", rsp_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_init_busy"}, int'(init_busy), 0);
    check({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    check({tag, "_rsp_way"}, int'(rsp_way), 0);
    check({tag, "_csb0"}, int'(lru_csb0), 1);
    check({tag, "_csb1"}, int'(lru_csb1), 1);
    check({tag, "_web0"}, int'(lru_web0), 1);
    check({tag, "_web1"}, int'(lru_web1), 1);
    check({tag, "_addr0"}, int'(lru_addr0), 0);
    check({tag, "_din0"}, int'(lru_din0), 0);
    check({tag, "_addr1"}, int'(lru_addr1), 0);
    check({tag, "_din1"}, int'(lru_din1), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_g [4];
    int g;
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;

    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("in_rst");
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_rst");
    tick();

    // Contention from reset: grants alternate hit, miss, hit, miss
    chk_arb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hit_valid = 1'b1;  hit_set  = S_INDEX'(9 + i); hit_way = 2'(i);
      miss_valid = 1'b1; miss_set = S_INDEX'(13 + (i % 2)); miss_alloc = 1'b1;
      @(negedge clk);
      g = hit_ready ? 0 : (miss_ready ? 1 : 2);
      check("contention_grant", g, exp_g[i]);
      tick();
    end
    drain();

    miss_op(5, 1'b1);
    miss_op(5, 1'b0);
    drain();

    hit_op(3, 0);
    hit_op(3, 1);
    hit_op(3, 2);
    hit_op(3, 3);
    hit_valid = 1'b0;
    miss_op(3, 1'b0);
    drain();
    check("set3_state", int'(mem[3]), 0);

    miss_op(7, 1'b1);
    miss_op(7, 1'b1);
    drain();

    // Touch, then init walk with a lookup held pending and a stray init_req mid-walk
    hit_op(2, 3);
    hit_set  = 4'd4;
    init_req = 1'b1;
    @(negedge clk);
    check("init_req_blocks_hit", int'(hit_ready), 0);
    tick();
    init_req   = 1'b0;
    hit_valid  = 1'b0;
    miss_valid = 1'b1; miss_set = 4'd2; miss_alloc = 1'b0;
    for (int i = 1; i <= NUM_SETS; i++) begin
      @(negedge clk);
      check("init_busy_high", int'(init_busy), 1);
      check("init_miss_blocked", int'(miss_ready), 0);
      tick();
      init_req = (i == 5);
    end
    @(negedge clk);
    check("init_busy_low", int'(init_busy), 0);
    check("first_accept_after_init", int'(miss_ready), 1);
    tick();
    drain();

    for (int i = 0; i < 400; i++) begin
      hit_valid  = ($urandom_range(0, 99) < 60);
      hit_set    = S_INDEX'($urandom_range(0, NUM_SETS - 1));
      hit_way    = 2'($urandom_range(0, 3));
      miss_valid = ($urandom_range(0, 99) < 60);
      miss_set   = S_INDEX'($urandom_range(0, 3));
      miss_alloc = 1'($urandom_range(0, 1));
      tick();
    end
    drain();

    // Reset in the cycle after a hit grant drops the pending write
    sb_en = 1'b0;
    hit_valid = 1'b1; hit_set = 4'd6; hit_way = 2'd1;
    @(negedge clk);
    check("rst_case_grant", int'(hit_ready), 1);
    tick();
    hit_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_drops_write_csb1", int'(lru_csb1), 1);
    check("rst_drops_write_web1", int'(lru_web1), 1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_abort");
    tick();
    sb_en = 1'b1;
    drain();

    for (int i = 0; i < NUM_SETS; i++) check("final_array_state", int'(mem[i]), ref_st[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
